dram_strobe_sequencer: RTL and testbench
========================================

// Module: dram_strobe_sequencer
// PURPOSE
// - Clocked replacement for a TTL delay-line DRAM timing chain (buffer/inverter delay taps).
// - Generates RAS/CAS/MUX/WE strobes for one DRAM bank.
// - Arbitrates between a single host request port and an internal periodic CAS-before-RAS refresh.
// - Sits between the host bus interface and the DRAM address multiplexer/driver models.
// PARAMETERS
// - T_RAS_MUX     1   cycles ras_n low before mux switches to column address (>=1)
// - T_MUX_CAS     1   cycles mux high before cas_n falls (>=1)
// - T_CAS         2   cycles cas_n low in an access cycle (>=1)
// - T_PRE         2   cycles precharge, both strobes high, after any cycle (>=1)
// - T_RRAS        3   cycles ras_n low during refresh (>=1)
// - REF_INTERVAL  64  cycles between refresh requests (>=8)
// - CNT_W         4   width of the phase counter; all T_* parameters must be < 2**CNT_W
// - REF_W         8   width of the refresh timer; REF_INTERVAL must be <= 2**REF_W
// PORTS
// - clk          in   1  rising-edge clock
// - clr_n        in   1  synchronous active-low reset
// - req          in   1  host access request, level, held until ack
// - wr           in   1  1 = write, 0 = read; sampled with req in IDLE
// - ack          out  1  one-cycle pulse, data valid (read) or taken (write)
// - busy         out  1  high whenever not in IDLE
// - ras_n        out  1  row strobe, active low
// - cas_n        out  1  column strobe, active low
// - mux          out  1  0 = row address, 1 = column address
// - we_n         out  1  write enable, active low
// - ref_pending  out  1  refresh requested but not yet started
// - ref_miss     out  1  sticky: interval elapsed while ref_pending was still set
// BEHAVIOUR
// - All outputs are registered.
// - Reset (clr_n=0 at an edge) gives state IDLE, ras_n=cas_n=we_n=1, mux=ack=busy=0, ref timer=0,
//   ref_pending=0, ref_miss=0.
// - Reset mid-cycle aborts the cycle immediately; no ack is issued.
// - Refresh timer counts every cycle, including during access cycles.
//   - At count REF_INTERVAL-1 it wraps to 0 and sets ref_pending.
//   - If ref_pending is already 1 at wrap, ref_miss is set. Only reset clears ref_miss.
// - Arbitration happens in IDLE only. ref_pending has priority over req when both are present.
// - A phase counter loads T_x-1 on state entry; the state exits when the counter reaches 0.
// - States and outputs:
//   - IDLE: strobes high, mux=0. ref_pending -> RCAS; else req -> ROW, latching wr into wr_q.
//   - ROW: ras_n=0, mux=0, T_RAS_MUX cycles -> COL.
//   - COL: ras_n=0, mux=1, we_n=~wr_q, T_MUX_CAS cycles -> CAS.
//   - CAS: ras_n=0, cas_n=0, mux=1, we_n=~wr_q, T_CAS cycles; ack=1 on the last CAS cycle -> PRE.
//   - RCAS: cas_n=0, 1 cycle; ref_pending cleared on entry -> RRAS.
//   - RRAS: cas_n=0, ras_n=0, T_RRAS cycles -> PRE.
//   - PRE: strobes high, we_n=1, mux=0, T_PRE cycles -> IDLE.
// - Latency: req high before edge n puts ras_n low after edge n. Default read cycle is 6 busy cycles,
//   with ack in cycle 4 counted from ras_n fall = cycle 1.
// - req dropped mid-cycle: the cycle completes and ack is still pulsed.
// - req held after ack: a new cycle starts only after PRE and IDLE (minimum one IDLE cycle).
// - wr changing mid-cycle is ignored; wr_q is used.
// - A refresh wrap during an access cycle sets ref_pending; refresh starts at the next IDLE, ahead of req.
// - Illegal state encoding recovers to PRE.
// STRUCTURE
// - Include file dram_strobe_defs.vh: state encodings (3-bit localparams IDLE, ROW, COL, CAS, RCAS,
//   RRAS, PRE) and the output-vector bit positions.
// - Sub-module dram_strobe_reftmr: refresh interval counter, ref_pending set/clear, ref_miss logic.
// - Top level: state register, phase counter, wr_q, registered strobe decode.
// TESTING
// - Reset: hold clr_n=0 for 3 cycles with req=1 -> ras_n=cas_n=we_n=1, mux=ack=busy=0 throughout.
// - Read with defaults: req=1, wr=0 at cycle 0 -> ras_n low cycles 1-4, mux=1 cycles 2-4,
//   cas_n low cycles 3-4, ack in cycle 4, we_n=1, busy cycles 1-6, idle at 7.
// - Write: same timing with wr=1 -> we_n low cycles 2-4; toggling wr in cycle 2 has no effect.
// - Refresh: no req for 64 cycles -> ref_pending at 64, cas_n low from 65, ras_n low 66-68,
//   PRE 69-70, ref_pending=0 from 65.
// - Conflict: req asserted in the same IDLE cycle as ref_pending -> refresh first, then access
//   starts after its PRE plus one IDLE cycle; exactly one ack.
// - Miss and abort: REF_INTERVAL=8 with back-to-back reqs blocking refresh across two wraps ->
//   ref_miss=1 and sticky. Then clr_n=0 during CAS -> no ack, all outputs at reset values next cycle.

Source files
------------

// File: rtl/dram_strobe_sequencer_pkg.sv
// Shared state encodings, output-vector bit positions and strobe decode
// for the DRAM strobe sequencer.
package dram_strobe_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW  = 3'd1,
    COL  = 3'd2,
    CAS  = 3'd3,
    RCAS = 3'd4,
    RRAS = 3'd5,
    PRE  = 3'd6
  } state_t;

  localparam int OB_ACK  = 0;
  localparam int OB_BUSY = 1;
  localparam int OB_RAS  = 2;
  localparam int OB_CAS  = 3;
  localparam int OB_MUX  = 4;
  localparam int OB_WE   = 5;
  localparam int OUT_W   = 6;

  // Strobes inactive, mux on row, no ack, not busy
  localparam logic [OUT_W-1:0] OUT_RESET = 6'b101100;

  function automatic state_t succ(input state_t s);
    state_t n;
    case (s)
      ROW:     n = COL;
      COL:     n = CAS;
      CAS:     n = PRE;
      RCAS:    n = RRAS;
      RRAS:    n = PRE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // last marks the final cycle of the state, which only matters for CAS (ack)
  function automatic logic [OUT_W-1:0] decode(input state_t s, input logic write, input logic last);
    logic [OUT_W-1:0] o;
    o = OUT_RESET;
    o[OB_BUSY] = (s != IDLE);
    case (s)
      ROW: o[OB_RAS] = 1'b0;
      COL: begin
        o[OB_RAS] = 1'b0;
        o[OB_MUX] = 1'b1;
        o[OB_WE]  = ~write;
      end
      CAS: begin
        o[OB_RAS] = 1'b0;
        o[OB_CAS] = 1'b0;
        o[OB_MUX] = 1'b1;
        o[OB_WE]  = ~write;
        o[OB_ACK] = last;
      end
      RCAS: o[OB_CAS] = 1'b0;
      RRAS: begin
        o[OB_CAS] = 1'b0;
        o[OB_RAS] = 1'b0;
      end
      default: o[OB_MUX] = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dram_strobe_sequencer_reftmr.sv
// Refresh interval timer: raises ref_pending every REF_INTERVAL cycles and
// flags a sticky ref_miss when a previous request was never serviced.
module dram_strobe_sequencer_reftmr #(
  parameter int REF_INTERVAL = 64,
  parameter int REF_W        = 8
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  output logic ref_pending,
  output logic ref_miss
);

  localparam logic [REF_W-1:0] LAST = REF_W'(REF_INTERVAL - 1);

  logic [REF_W-1:0] tmr;

  // A wrap coinciding with a refresh start re-arms the request for the new interval
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      tmr         <= '0;
      ref_pending <= 1'b0;
      ref_miss    <= 1'b0;
    end else if (tmr == LAST) begin
      tmr         <= '0;
      ref_pending <= 1'b1;
      if (ref_pending) ref_miss <= 1'b1;
    end else begin
      tmr <= tmr + REF_W'(1);
      if (start) ref_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_strobe_sequencer.sv
// Clocked RAS/CAS/MUX/WE strobe generator for one DRAM bank, arbitrating
// host accesses against periodic CAS-before-RAS refresh.
module dram_strobe_sequencer
  import dram_strobe_sequencer_pkg::*;
#(
  parameter int T_RAS_MUX    = 1,
  parameter int T_MUX_CAS    = 1,
  parameter int T_CAS        = 2,
  parameter int T_PRE        = 2,
  parameter int T_RRAS       = 3,
  parameter int REF_INTERVAL = 64,
  parameter int CNT_W        = 4,
  parameter int REF_W        = 8
) (
  input  logic clk,
  input  logic clr_n,
  input  logic req,
  input  logic wr,
  output logic ack,
  output logic busy,
  output logic ras_n,
  output logic cas_n,
  output logic mux,
  output logic we_n,
  output logic ref_pending,
  output logic ref_miss
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               wr_q;
  logic [OUT_W-1:0]   outs;

  function automatic logic [CNT_W-1:0] load(input state_t s);
    logic [CNT_W-1:0] v;
    case (s)
      ROW:     v = CNT_W'(T_RAS_MUX - 1);
      COL:     v = CNT_W'(T_MUX_CAS - 1);
      CAS:     v = CNT_W'(T_CAS - 1);
      RRAS:    v = CNT_W'(T_RRAS - 1);
      PRE:     v = CNT_W'(T_PRE - 1);
      default: v = '0;
    endcase
    return v;
  endfunction

  dram_strobe_sequencer_reftmr #(
    .REF_INTERVAL(REF_INTERVAL),
    .REF_W       (REF_W)
  ) u_reftmr (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      ((state == IDLE) && ref_pending),
    .ref_pending(ref_pending),
    .ref_miss   (ref_miss)
  );

  // Outputs are decoded from the state being entered so they line up with it
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
      cnt   <= '0;
      wr_q  <= 1'b0;
      outs  <= OUT_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (ref_pending) begin
            state <= RCAS;
            cnt   <= load(RCAS);
            outs  <= decode(RCAS, wr_q, load(RCAS) == '0);
          end else if (req) begin
            state <= ROW;
            cnt   <= load(ROW);
            wr_q  <= wr;
            outs  <= decode(ROW, wr, load(ROW) == '0);
          end else begin
            outs  <= decode(IDLE, wr_q, 1'b0);
          end
        end
        ROW, COL, CAS, RCAS, RRAS, PRE: begin
          if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            outs <= decode(state, wr_q, cnt == CNT_W'(1));
          end else begin
            state <= succ(state);
            cnt   <= load(succ(state));
            outs  <= decode(succ(state), wr_q, load(succ(state)) == '0);
          end
        end
        default: begin
          state <= PRE;
          cnt   <= load(PRE);
          outs  <= decode(PRE, wr_q, 1'b0);
        end
      endcase
    end
  end

  assign ack   = outs[OB_ACK];
  assign busy  = outs[OB_BUSY];
  assign ras_n = outs[OB_RAS];
  assign cas_n = outs[OB_CAS];
  assign mux   = outs[OB_MUX];
  assign we_n  = outs[OB_WE];

endmodule

// File: tb/tb_dram_strobe_sequencer.sv
// Directed, table-driven bench for dram_strobe_sequencer: default instance for
// access/refresh timing, a short-interval long-CAS instance for miss and abort.
module tb_dram_strobe_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n_a, req_a, wr_a;
  logic ack_a, busy_a, ras_n_a, cas_n_a, mux_a, we_n_a, pend_a, miss_a;
  logic clr_n_b, req_b, wr_b;
  logic ack_b, busy_b, ras_n_b, cas_n_b, mux_b, we_n_b, pend_b, miss_b;

  int checks   = 0;
  int failures = 0;

  dram_strobe_sequencer dut_a (
    .clk(clk), .clr_n(clr_n_a), .req(req_a), .wr(wr_a),
    .ack(ack_a), .busy(busy_a), .ras_n(ras_n_a), .cas_n(cas_n_a),
    .mux(mux_a), .we_n(we_n_a), .ref_pending(pend_a), .ref_miss(miss_a)
  );

  dram_strobe_sequencer #(.T_CAS(12), .REF_INTERVAL(8)) dut_b (
    .clk(clk), .clr_n(clr_n_b), .req(req_b), .wr(wr_b),
    .ack(ack_b), .busy(busy_b), .ras_n(ras_n_b), .cas_n(cas_n_b),
    .mux(mux_b), .we_n(we_n_b), .ref_pending(pend_b), .ref_miss(miss_b)
  );

  // Packed as {ras_n, cas_n, mux, we_n, ack, busy, ref_pending, ref_miss}
  localparam logic [7:0] V_IDLE  = 8'b1101_0000;
  localparam logic [7:0] V_PEND  = 8'b1101_0010;
  localparam logic [7:0] V_ROW   = 8'b0101_0100;
  localparam logic [7:0] V_COLR  = 8'b0111_0100;
  localparam logic [7:0] V_CASR  = 8'b0011_0100;
  localparam logic [7:0] V_ACKR  = 8'b0011_1100;
  localparam logic [7:0] V_COLW  = 8'b0110_0100;
  localparam logic [7:0] V_CASW  = 8'b0010_0100;
  localparam logic [7:0] V_ACKW  = 8'b0010_1100;
  localparam logic [7:0] V_PRE   = 8'b1101_0100;
  localparam logic [7:0] V_RCAS  = 8'b1001_0100;
  localparam logic [7:0] V_RRAS  = 8'b0001_0100;

  typedef struct {
    logic       req;
    logic       wr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t rw_tab[15];
  vec_t cf_tab[14];

  function automatic logic [7:0] outs_a();
    return {ras_n_a, cas_n_a, mux_a, we_n_a, ack_a, busy_a, pend_a, miss_a};
  endfunction

  function automatic logic [7:0] outs_b();
    return {ras_n_b, cas_n_b, mux_b, we_n_b, ack_b, busy_b, pend_b, miss_b};
  endfunction

  task automatic applyStimulus(input logic r, input logic w);
    req_a = r;
    wr_a  = w;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [7:0] e, input string n);
    vec_t v;
    v.req = r; v.wr = w; v.exp = e; v.name = n;
    return v;
  endfunction

  initial begin
    int ack_cnt;
    logic found;
    logic [7:0] e;

    // Read (req held through ack), then write with wr toggled and req dropped mid-cycle
    rw_tab[0]  = mk(1, 0, V_ROW,  "rd_row");
    rw_tab[1]  = mk(1, 0, V_COLR, "rd_col");
    rw_tab[2]  = mk(1, 0, V_CASR, "rd_cas1");
    rw_tab[3]  = mk(1, 0, V_ACKR, "rd_cas2_ack");
    rw_tab[4]  = mk(1, 0, V_PRE,  "rd_pre1");
    rw_tab[5]  = mk(1, 0, V_PRE,  "rd_pre2");
    rw_tab[6]  = mk(1, 0, V_IDLE, "rd_idle_gap");
    rw_tab[7]  = mk(1, 1, V_ROW,  "wr_row");
    rw_tab[8]  = mk(1, 1, V_COLW, "wr_col");
    rw_tab[9]  = mk(0, 0, V_CASW, "wr_cas1_wrtoggle");
    rw_tab[10] = mk(0, 1, V_ACKW, "wr_cas2_ack");
    rw_tab[11] = mk(0, 0, V_PRE,  "wr_pre1");
    rw_tab[12] = mk(0, 0, V_PRE,  "wr_pre2");
    rw_tab[13] = mk(0, 0, V_IDLE, "wr_idle");
    rw_tab[14] = mk(0, 0, V_IDLE, "wr_idle2");

    // Refresh wins the IDLE cycle at 65, access follows after PRE plus one IDLE
    cf_tab[0]  = mk(1, 0, V_RCAS, "cf_rcas");
    cf_tab[1]  = mk(1, 0, V_RRAS, "cf_rras1");
    cf_tab[2]  = mk(1, 0, V_RRAS, "cf_rras2");
    cf_tab[3]  = mk(1, 0, V_RRAS, "cf_rras3");
    cf_tab[4]  = mk(1, 0, V_PRE,  "cf_pre1");
    cf_tab[5]  = mk(1, 0, V_PRE,  "cf_pre2");
    cf_tab[6]  = mk(1, 0, V_IDLE, "cf_idle");
    cf_tab[7]  = mk(1, 0, V_ROW,  "cf_row");
    cf_tab[8]  = mk(1, 0, V_COLR, "cf_col");
    cf_tab[9]  = mk(1, 0, V_CASR, "cf_cas1");
    cf_tab[10] = mk(1, 0, V_ACKR, "cf_cas2_ack");
    cf_tab[11] = mk(0, 0, V_PRE,  "cf_pre3");
    cf_tab[12] = mk(0, 0, V_PRE,  "cf_pre4");
    cf_tab[13] = mk(0, 0, V_IDLE, "cf_idle2");

    clr_n_a = 1'b0; clr_n_b = 1'b0;
    req_b = 1'b0; wr_b = 1'b0;
    applyStimulus(1, 0);

    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("reset_hold%0d", i), outs_a(), V_IDLE);
    end

    clr_n_a = 1'b1;
    foreach (rw_tab[i]) begin
      applyStimulus(rw_tab[i].req, rw_tab[i].wr);
      tick();
      checkOutput(rw_tab[i].name, outs_a(), rw_tab[i].exp);
    end

    // Idle refresh: pending at 64, RCAS 65, RRAS 66-68, PRE 69-70
    clr_n_a = 1'b0;
    applyStimulus(0, 0);
    tick();
    checkOutput("reset2", outs_a(), V_IDLE);
    clr_n_a = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      tick();
      if (k == 64)                 e = V_PEND;
      else if (k == 65)            e = V_RCAS;
      else if (k >= 66 && k <= 68) e = V_RRAS;
      else if (k >= 69 && k <= 70) e = V_PRE;
      else                         e = V_IDLE;
      checkOutput($sformatf("ref_c%0d", k), outs_a(), e);
    end

    clr_n_a = 1'b0;
    tick();
    checkOutput("reset3", outs_a(), V_IDLE);
    clr_n_a = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      checkOutput($sformatf("cf_pre_c%0d", k), outs_a(), (k == 64) ? V_PEND : V_IDLE);
    end
    ack_cnt = 0;
    foreach (cf_tab[i]) begin
      applyStimulus(cf_tab[i].req, cf_tab[i].wr);
      tick();
      if (ack_a) ack_cnt++;
      checkOutput(cf_tab[i].name, outs_a(), cf_tab[i].exp);
    end
    checkOutput("cf_ack_count", 8'(ack_cnt), 8'd1);

    // Short interval with long CAS: two wraps inside one access -> miss
    clr_n_b = 1'b1;
    req_b = 1'b1; wr_b = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      case (k)
        8:  checkOutput("b_pend_c8",   outs_b(), 8'b0011_0110);
        14: checkOutput("b_ack_c14",   outs_b(), 8'b0011_1110);
        15: checkOutput("b_nomiss_c15", outs_b(), 8'b1101_0110);
        16: checkOutput("b_miss_c16",  outs_b(), 8'b1101_0111);
        18: checkOutput("b_rcas_c18",  outs_b(), 8'b1001_0101);
        31: checkOutput("b_sticky_c31", outs_b(), 8'b1101_0001);
        default: ;
      endcase
    end

    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick();
      if (mux_b === 1'b1 && cas_n_b === 1'b0) found = 1'b1;
    end
    checkOutput("b_cas_reached", {7'b0, found}, 8'd1);
    checkOutput("b_cas_noack", {7'b0, ack_b}, 8'd0);

    clr_n_b = 1'b0;
    tick();
    checkOutput("b_abort_reset", outs_b(), V_IDLE);
    clr_n_b = 1'b1;
    req_b = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("b_after_abort%0d", k), outs_b(), V_IDLE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
